// File: rtl/io_input_conditioner.sv
// Board input front end: synchronizes and debounces raw switch/button pins, then derives
// per-button one-cycle press pulses and software-clearable sticky press flags.
module io_input_conditioner #(
  parameter int unsigned N_SW            = 32,
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SW-1:0]  i_sw_raw,
  input  logic [N_BTN-1:0] i_btn_raw,
  input  logic [N_BTN-1:0] i_btn_clr,
  output logic [N_SW-1:0]  o_io_sw,
  output logic [N_BTN-1:0] o_io_btn,
  output logic [N_BTN-1:0] o_btn_pulse,
  output logic [N_BTN-1:0] o_btn_press
);

  localparam int unsigned NAll = N_SW + N_BTN;
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  // Button stages reset to the idle pin level so an idle pin produces no event after reset.
  localparam logic [N_BTN-1:0] BtnIdle = BTN_ACTIVE_LOW ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  logic [N_SW-1:0]  sw_sync_q  [SYNC_STAGES];
  logic [N_SW-1:0]  sw_sync_d  [SYNC_STAGES];
  logic [N_BTN-1:0] btn_sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] btn_sync_d [SYNC_STAGES];

  logic [NAll-1:0]  s_all;
  logic [NAll-1:0]  stable_q, stable_d;
  logic [CntW-1:0]  cnt_q [NAll];
  logic [CntW-1:0]  cnt_d [NAll];

  logic [N_BTN-1:0] btn_stable_q, btn_stable_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [N_BTN-1:0] press_q, press_d;

  always_comb begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sw_sync_d[i]  = sw_sync_q[i];
      btn_sync_d[i] = btn_sync_q[i];
    end
    sw_sync_d[0]  = i_sw_raw;
    btn_sync_d[0] = i_btn_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sw_sync_d[i]  = sw_sync_q[i-1];
      btn_sync_d[i] = btn_sync_q[i-1];
    end
  end

  // Buttons become active-high after the last synchronizer stage.
  assign s_all = {btn_sync_q[SYNC_STAGES-1] ^ {N_BTN{BTN_ACTIVE_LOW}},
                  sw_sync_q[SYNC_STAGES-1]};

  // Per-bit debounce: count consecutive mismatch edges; any agreement restarts from zero.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NAll; i++) begin
      cnt_d[i] = '0;
      if (s_all[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = s_all[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  assign btn_stable_q = stable_q[NAll-1:N_SW];
  assign btn_stable_d = stable_d[NAll-1:N_SW];

  // Pulse is registered alongside the level it qualifies; set beats clear on the flag.
  always_comb begin
    pulse_d = btn_stable_d & ~btn_stable_q;
    press_d = pulse_d | (press_q & ~i_btn_clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i]  <= '0;
        btn_sync_q[i] <= BtnIdle;
      end
      for (int i = 0; i < NAll; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q <= '0;
      pulse_q  <= '0;
      press_q  <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i]  <= sw_sync_d[i];
        btn_sync_q[i] <= btn_sync_d[i];
      end
      for (int i = 0; i < NAll; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      press_q  <= press_d;
    end
  end

  assign o_io_sw     = stable_q[N_SW-1:0];
  assign o_io_btn    = btn_stable_q;
  assign o_btn_pulse = pulse_q;
  assign o_btn_press = press_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner at default parameters: a vector table walks reset,
// press/release, flag clear and reset-mid-debounce; hand sequences cover glitch and bounce.
module tb_io_input_conditioner;

  logic        clk;
  logic        rst;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [3:0]  btn_clr;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [3:0]  btn_pulse;
  logic [3:0]  btn_press;

  int checks;
  int errors;
  int pulse_cnt;

  io_input_conditioner dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sw_raw    (sw_raw),
    .i_btn_raw   (btn_raw),
    .i_btn_clr   (btn_clr),
    .o_io_sw     (io_sw),
    .o_io_btn    (io_btn),
    .o_btn_pulse (btn_pulse),
    .o_btn_press (btn_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [3:0]  clr;
    int          cyc;
    logic [31:0] e_sw;
    logic [3:0]  e_btn;
    logic [3:0]  e_pulse;
    logic [3:0]  e_press;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [31:0] sw, input logic [3:0] btn,
                              input logic [3:0] clr, input int cyc, input logic [31:0] e_sw,
                              input logic [3:0] e_btn, input logic [3:0] e_pulse,
                              input logic [3:0] e_press, input string name);
    vec_t v;
    v.rst = r; v.sw = sw; v.btn = btn; v.clr = clr; v.cyc = cyc;
    v.e_sw = e_sw; v.e_btn = e_btn; v.e_pulse = e_pulse; v.e_press = e_press; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge and tallying button-0 pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (btn_pulse[0] === 1'b1) pulse_cnt++;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    rst       = 1'b1;
    sw_raw    = '0;
    btn_raw   = 4'hF;
    btn_clr   = '0;

    //           rst  sw            btn      clr      cyc e_sw          e_btn    e_pulse  e_press
    tbl.push_back(mk(1, 32'h0,        4'b1111, 4'b0000, 3,  32'h0,        4'h0, 4'h0, 4'h0, "reset"));
    tbl.push_back(mk(0, 32'h0,        4'b1111, 4'b0000, 40, 32'h0,        4'h0, 4'h0, 4'h0, "idle40"));
    tbl.push_back(mk(0, 32'h0,        4'b0111, 4'b0000, 17, 32'h0,        4'h0, 4'h0, 4'h0, "b3_edge17"));
    tbl.push_back(mk(0, 32'h0,        4'b0111, 4'b0000, 1,  32'h0,        4'h8, 4'h8, 4'h8, "b3_edge18"));
    tbl.push_back(mk(0, 32'h0,        4'b0111, 4'b0000, 1,  32'h0,        4'h8, 4'h0, 4'h8, "b3_after"));
    tbl.push_back(mk(0, 32'h0,        4'b1111, 4'b0000, 17, 32'h0,        4'h8, 4'h0, 4'h8, "b3_rel17"));
    tbl.push_back(mk(0, 32'h0,        4'b1111, 4'b0000, 1,  32'h0,        4'h0, 4'h0, 4'h8, "b3_rel18"));
    tbl.push_back(mk(0, 32'h0,        4'b1111, 4'b1000, 1,  32'h0,        4'h0, 4'h0, 4'h0, "b3_clr"));
    tbl.push_back(mk(0, 32'h0,        4'b1101, 4'b0000, 18, 32'h0,        4'h2, 4'h2, 4'h2, "b1_press"));
    tbl.push_back(mk(0, 32'h0,        4'b1101, 4'b0010, 1,  32'h0,        4'h2, 4'h0, 4'h0, "b1_clr_held"));
    tbl.push_back(mk(0, 32'h0,        4'b1101, 4'b0000, 5,  32'h0,        4'h2, 4'h0, 4'h0, "b1_stays_clr"));
    tbl.push_back(mk(0, 32'h0,        4'b1111, 4'b0000, 18, 32'h0,        4'h0, 4'h0, 4'h0, "b1_rel"));
    tbl.push_back(mk(0, 32'h0,        4'b1101, 4'b0000, 17, 32'h0,        4'h0, 4'h0, 4'h0, "b1_re17"));
    tbl.push_back(mk(0, 32'h0,        4'b1101, 4'b0010, 1,  32'h0,        4'h2, 4'h2, 4'h2, "set_wins"));
    tbl.push_back(mk(0, 32'h0,        4'b1101, 4'b0000, 1,  32'h0,        4'h2, 4'h0, 4'h2, "set_held"));
    tbl.push_back(mk(0, 32'h0,        4'b1111, 4'b0000, 18, 32'h0,        4'h0, 4'h0, 4'h2, "b1_rel2"));
    tbl.push_back(mk(0, 32'hA5A50001, 4'b1111, 4'b0000, 9,  32'h0,        4'h0, 4'h0, 4'h2, "sw_edge9"));
    tbl.push_back(mk(1, 32'hA5A50001, 4'b1111, 4'b0000, 1,  32'h0,        4'h0, 4'h0, 4'h0, "mid_rst"));
    tbl.push_back(mk(0, 32'hA5A50001, 4'b1111, 4'b0000, 8,  32'h0,        4'h0, 4'h0, 4'h0, "sw_edge18"));
    tbl.push_back(mk(0, 32'hA5A50001, 4'b1111, 4'b0000, 9,  32'h0,        4'h0, 4'h0, 4'h0, "sw_post17"));
    tbl.push_back(mk(0, 32'hA5A50001, 4'b1111, 4'b0000, 1,  32'hA5A50001, 4'h0, 4'h0, 4'h0, "sw_post18"));
    tbl.push_back(mk(0, 32'hA5A50000, 4'b1111, 4'b0000, 17, 32'hA5A50001, 4'h0, 4'h0, 4'h0, "bit0_17"));
    tbl.push_back(mk(0, 32'hA5A50000, 4'b1111, 4'b0000, 1,  32'hA5A50000, 4'h0, 4'h0, 4'h0, "bit0_18"));

    foreach (tbl[k]) begin
      rst     = tbl[k].rst;
      sw_raw  = tbl[k].sw;
      btn_raw = tbl[k].btn;
      btn_clr = tbl[k].clr;
      step(tbl[k].cyc);
      check({tbl[k].name, ".sw"},    io_sw,            tbl[k].e_sw);
      check({tbl[k].name, ".btn"},   32'(io_btn),      32'(tbl[k].e_btn));
      check({tbl[k].name, ".pulse"}, 32'(btn_pulse),   32'(tbl[k].e_pulse));
      check({tbl[k].name, ".press"}, 32'(btn_press),   32'(tbl[k].e_press));
    end
    rst     = 1'b0;
    btn_clr = '0;

    // Glitch: bit 0 high for 10 cycles then back; the output must never move.
    sw_raw = 32'hA5A50001;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch_hi", io_sw, 32'hA5A50000);
    end
    sw_raw = 32'hA5A50000;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("glitch_lo", io_sw, 32'hA5A50000);
    end

    // Bounce on button 0: 3-cycle excursions, then settle pressed.
    pulse_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      btn_raw = (b % 2 == 0) ? 4'b1110 : 4'b1111;
      for (int i = 0; i < 3; i++) begin
        step(1);
        check("bounce_btn0", 32'(io_btn), 32'h0);
      end
    end
    btn_raw = 4'b1110;
    step(17);
    check("bounce_17", 32'(io_btn), 32'h0);
    step(1);
    check("bounce_18", 32'(io_btn), 32'h1);
    check("bounce_pulse18", 32'(btn_pulse), 32'h1);
    check("bounce_press18", 32'(btn_press), 32'h1);
    step(10);
    check("bounce_pulses", 32'(pulse_cnt), 32'd1);
    check("bounce_hold", 32'(io_btn), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
Front end for the board inputs consumed by the singlecycle core's i_io_sw / i_io_btn ports. Takes raw, asynchronous, bouncing switch and push-button pins and delivers synchronized, debounced, active-high levels. Also produces per-button one-cycle press pulses and sticky press flags that software clears through a mask. Sits between the top-level pins and the LSU input-memory region.

Parameters:
N_SW, 32, number of switch inputs
N_BTN, 4, number of button inputs
SYNC_STAGES, 2, flip-flop synchronizer depth (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a new level (>=2; board build uses ~1_000_000)
BTN_ACTIVE_LOW, 1, 1 = raw button pin reads 0 when pressed (inverted after sync)

Ports:
i_clk  in  1  system clock; single clock domain
i_rst  in  1  synchronous reset, active-high
i_sw_raw  in  N_SW  raw switch pins, asynchronous
i_btn_raw  in  N_BTN  raw button pins, asynchronous, polarity per BTN_ACTIVE_LOW
i_btn_clr  in  N_BTN  clear mask for o_btn_press; bit k clears flag k
o_io_sw  out  N_SW  debounced switch levels; feeds core i_io_sw
o_io_btn  out  N_BTN  debounced button levels, 1 = pressed; feeds core i_io_btn
o_btn_pulse  out  N_BTN  one-cycle pulse per accepted press (0->1 of o_io_btn)
o_btn_press  out  N_BTN  sticky press flags

Behaviour:
- Reset is synchronous and active-high; one clock: i_clk. On any rising edge with i_rst=1:
  - o_io_sw, o_io_btn, o_btn_pulse and o_btn_press = 0.
  - All debounce counters = 0.
  - Switch synchronizer stages = 0.
  - Button synchronizer stages = the inactive level (1 if BTN_ACTIVE_LOW, else 0), so a held-at-idle pin creates no event after reset.
- Reset mid-debounce discards the partial count. The count restarts from 0 after reset deasserts.
- Synchronizer: SYNC_STAGES registers per bit. Button bits are inverted after the last stage when BTN_ACTIVE_LOW=1, giving s = synchronized active-high level.
- Debounce is per bit and independent across bits. It uses a counter of width $clog2(DEBOUNCE_CYCLES) and a stable register that drives the output. At each edge:
  - s == stable: counter <= 0.
  - s != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s != stable and counter == DEBOUNCE_CYCLES-1: stable <= s; counter <= 0.
- Latency: a raw change held clean updates the output at the rising edge numbered SYNC_STAGES+DEBOUNCE_CYCLES. Edge 1 is the first edge that samples the new raw value. Defaults give 18 edges.
- Glitch rejection: any raw excursion that leaves s differing from stable for fewer than DEBOUNCE_CYCLES consecutive edges produces no output change. Any return to the stable value resets the count to 0.
- Bounce during a transition restarts the count on each return. The output changes only after DEBOUNCE_CYCLES uninterrupted mismatch edges.
- o_btn_pulse[k] is registered: 1 for exactly one cycle, asserted on the same edge that o_io_btn[k] goes 0->1. There is no pulse on release.
- o_btn_press[k], evaluated each edge:
  - Set on the edge where the press pulse is generated.
  - Else cleared when i_btn_clr[k]=1.
  - Else held.
  - Set and clear on the same edge: set wins (the flag stays 1).
  - Clear while the button is still held: the flag stays 0 until the next accepted press.
- Switches have no pulse or flag outputs.
- A counter at its maximum never wraps. It is always either reset to 0 or consumed by a stable update.
- No combinational path from any input to any output.

Test Plan:
1. Reset state: assert i_rst 3 cycles with i_btn_raw=4'b1111, i_sw_raw=0 -> all outputs 0. Hold 40 cycles after release -> all outputs still 0.
2. Clean press, defaults: drive i_btn_raw=4'b0111 (button 3 pressed) and hold.
   - o_io_btn becomes 4'b1000 exactly at edge 18.
   - o_btn_pulse=4'b1000 for that one cycle only.
   - o_btn_press=4'b1000 thereafter.
3. Glitch rejection: i_sw_raw[0]=1 for 10 cycles, then 0 -> o_io_sw stays 0 throughout.
4. Bounce then settle: i_btn_raw[0] toggles 1,0,1,0 at 3-cycle spacing, then holds 0.
   - o_io_btn[0] rises exactly 18 edges after the final 1->0.
   - Exactly one o_btn_pulse[0].
5. Flag clear race: with o_btn_press[1]=1, pulse i_btn_clr=4'b0010 for 1 cycle -> flag 0. Then align i_btn_clr[1]=1 with a new press-pulse edge -> flag remains 1.
6. Reset mid-debounce, and multi-bit independence:
   - Set i_sw_raw=32'hA5A5_0001, assert i_rst at edge 10 for 1 cycle -> o_io_sw still 0 at edge 18. It reaches 32'hA5A5_0001 exactly 18 edges after reset deassertion.
   - Change only bit 0 to 0 afterwards -> only o_io_sw[0] changes, 18 edges later.
